sdram_dma_writer: RTL and testbench
===================================

# sdram_dma_writer

Page-write DMA engine for the SDRAM subsystem. It takes one page of 16-bit words from a ping-pong dual-port buffer pair (A/B) and writes it to SDRAM as a single burst through the SDRAM controller's write port. It sits beside the SDRAM bus bridge and uses the same request/ack handshake and burst interface as the page-read DMA path, in the opposite direction.

## Interface
- BURST_LEN, 256, words per page; power of two, 2..256
- PAGE_W, 16, page index width; SDRAM word address = {page, log2(BURST_LEN) zero bits}, 24 bits total
- clk  in  1  controller clock, same clock as the SDRAM controller
- reset  in  1  synchronous, active-high
- buffDMAwrite_req  in  1  transfer request; four-phase
- buffDMAwrite_ack  out  1  transfer complete; four-phase
- buffDMAwrite_addr  in  PAGE_W  page index; sampled at start
- buffDMAwrite_A_B  in  1  source select, 1 = buffer A, 0 = buffer B; sampled at start
- buffDMAwrite_rdaddress  out  8  buffer read address, shared by A and B
- buffDMAwriteA_q  in  16  buffer A data; registered address, 1-cycle latency
- buffDMAwriteB_q  in  16  buffer B data; same latency
- sdram_wr_req  out  1  controller write request
- sdram_wr_ack  in  1  controller accepts sdram_din on every edge where this is high
- sdram_rw_addr  out  24  burst start word address
- sdram_wr_burst  out  10  burst length, constant BURST_LEN
- sdram_din  out  16  write data
- sdram_mask  out  2  byte mask, constant 2'b00

## Operation
- The request is registered once into req_buff. All decisions use req_buff, never raw req.
- States:
  - IDLE: idx=0. On req_buff & !ack: latch page and A_B, clear idx → PREFETCH.
  - PREFETCH: one cycle for buffer q to become valid → BURST, set sdram_wr_req=1.
  - BURST: each edge with sdram_wr_ack=1 increments idx. On the edge accepting word BURST_LEN-1: wr_req←0, ack←1 → DONE.
  - DONE: on !req_buff: ack←0 → IDLE.
- rdaddress = sdram_wr_ack ? idx+1 : idx. This is combinational from registered idx, so q always holds word[idx].
- sdram_din = latched A_B ? A_q : B_q. This path is combinational with no extra register.
- idx is log2(BURST_LEN)+1 bits wide. rdaddress takes the low 8 bits. The last-word lookahead read (idx+1 = BURST_LEN) wraps to 0 and is harmless.
- sdram_wr_ack outside BURST is ignored, with no counter change.
- A req drop during PREFETCH or BURST is ignored. The page completes, then ack is issued; DONE sees !req_buff and returns to IDLE after one ack pulse.
- req held high after ack: remains in DONE. No second transfer starts until req falls and rises again.

## Timing
- Reset values: ack=0, sdram_wr_req=0, sdram_rw_addr=0, sdram_wr_burst=BURST_LEN, sdram_mask=0, idx=0, state=IDLE. rdaddress=0 and sdram_din follow B_q (A_B latch resets to 0).
- Reset mid-burst drops wr_req on the next edge. The controller is reset together with this block.
- Start latency: req high at edge E0 → req_buff E0 → IDLE→PREFETCH at E1 → wr_req=1 after E2.
- Completion: ack rises on the edge accepting the last word. Minimum total = 3 + BURST_LEN + controller latency.
- Ack fall: one edge after req_buff falls, i.e. two edges after req falls.
- Throughput: one word per wr_ack cycle. Gaps in wr_ack are tolerated.

## Configuration
- SDRAM_DMA_WRITE_CHECKSUM_EN
  - Defined: adds output buffDMAwrite_sum[15:0]. It is cleared on the IDLE→PREFETCH edge and adds sdram_din (mod 2^16) on each accepted word. It is stable from the ack edge until the next start.
  - Undefined: the port and adder are absent; the core FSM is unchanged.

## Structure
- Shared package sdram_dma_pkg holds:
  - state enum (IDLE, PREFETCH, BURST, DONE)
  - SDRAM_ADDR_W=24
  - SDRAM_BURST_W=10
  - the page-to-word-address function, shared with the read DMA
- No sub-module; single FSM plus counter.
- The optional checksum is an inline guarded block, not a separate module.

## Test plan
- Reset mid-BURST (idx=100): wr_req=0 and ack=0 after the reset edge. A fresh request afterwards writes words 0..255 correctly.
- Page 0x0012, A_B=1, buffer A[i]=i, wr_ack continuous → sdram_rw_addr=0x001200, burst=256, din sequence 0..255, ack after the 256th accepted word, wr_req low on that same edge.
- A_B=0, B[i]=0xFFFF−i, wr_ack toggling 1/0 → all 256 words written in order with none skipped or repeated, and rdaddress correct across gaps.
- req dropped two cycles into BURST → full page still written, one ack pulse, return to IDLE; spurious wr_ack in IDLE leaves idx=0.
- req held high after ack for 20 cycles → no second wr_req. Drop req → ack low two edges later. Re-raise req → second transfer with new page 0xFFFF → addr 0xFFFF00.
- With SDRAM_DMA_WRITE_CHECKSUM_EN and A[i]=i → buffDMAwrite_sum=0x7F80 at ack.

Source files
------------

// File: rtl/sdram_dma_pkg.sv
// Shared definitions for the SDRAM page DMA engines (read and write paths).
//   dma_state_t        : page-transfer FSM states
//   SDRAM_ADDR_W       : SDRAM word-address width
//   SDRAM_BURST_W      : controller burst-length field width
//   page_to_word_addr(): page index -> burst start word address
package sdram_dma_pkg;

   localparam int unsigned SDRAM_ADDR_W  = 24;
   localparam int unsigned SDRAM_BURST_W = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREFETCH = 2'd1,
      BURST    = 2'd2,
      DONE     = 2'd3
   } dma_state_t;

   // A page is one burst, so the word address is the page index shifted past the in-page offset
   function automatic logic [SDRAM_ADDR_W-1:0] page_to_word_addr(
      input logic [SDRAM_ADDR_W-1:0] page,
      input int unsigned             burst_log2
   );
      return page << burst_log2;
   endfunction

endpackage : sdram_dma_pkg

// File: rtl/sdram_dma_writer.sv
// Page-write DMA: streams one page of 16-bit words from ping-pong buffer A or B
// into the SDRAM controller write port as a single burst.
//
// Ports
//   clk, reset                  controller clock, synchronous active-high reset
//   buffDMAwrite_req/_ack       four-phase transfer handshake
//   buffDMAwrite_addr           page index, sampled at start
//   buffDMAwrite_A_B            source select (1 = A, 0 = B), sampled at start
//   buffDMAwrite_rdaddress      shared buffer read address (combinational)
//   buffDMAwriteA_q / B_q       buffer read data, one cycle after address
//   sdram_wr_req / sdram_wr_ack controller write request / per-word accept
//   sdram_rw_addr               burst start word address
//   sdram_wr_burst              burst length (constant BURST_LEN)
//   sdram_din                   write data (combinational from selected buffer)
//   sdram_mask                  byte mask (constant 0)
//   buffDMAwrite_sum            16-bit sum of written words, only when
//                               SDRAM_DMA_WRITE_CHECKSUM_EN is defined
module sdram_dma_writer
   import sdram_dma_pkg::*;
#(
   parameter int unsigned BURST_LEN = 256,
   parameter int unsigned PAGE_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     buffDMAwrite_req,
   output logic                     buffDMAwrite_ack,
   input  logic [PAGE_W-1:0]        buffDMAwrite_addr,
   input  logic                     buffDMAwrite_A_B,
   output logic [7:0]               buffDMAwrite_rdaddress,
   input  logic [15:0]              buffDMAwriteA_q,
   input  logic [15:0]              buffDMAwriteB_q,
   output logic                     sdram_wr_req,
   input  logic                     sdram_wr_ack,
   output logic [SDRAM_ADDR_W-1:0]  sdram_rw_addr,
   output logic [SDRAM_BURST_W-1:0] sdram_wr_burst,
   output logic [15:0]              sdram_din,
   output logic [1:0]               sdram_mask
`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
   ,
   output logic [15:0]              buffDMAwrite_sum
`endif
);

   localparam int unsigned LOG2_BL = $clog2(BURST_LEN);
   // One extra bit so idx can reach BURST_LEN after the final accept
   localparam int unsigned IDX_W   = LOG2_BL + 1;

   dma_state_t       state;
   logic             req_buff;
   logic             sel_a;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] rd_idx;

   // Look one word ahead when the controller is taking the current one so q stays aligned to idx
   always_comb begin
      rd_idx                 = sdram_wr_ack ? (idx + IDX_W'(1)) : idx;
      buffDMAwrite_rdaddress = 8'(rd_idx);
      sdram_din              = sel_a ? buffDMAwriteA_q : buffDMAwriteB_q;
   end

   // Transfer FSM, word counter and registered controller-side outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         req_buff         <= 1'b0;
         sel_a            <= 1'b0;
         idx              <= '0;
         buffDMAwrite_ack <= 1'b0;
         sdram_wr_req     <= 1'b0;
         sdram_rw_addr    <= '0;
         sdram_wr_burst   <= SDRAM_BURST_W'(BURST_LEN);
         sdram_mask       <= 2'b00;
      end else begin
         req_buff       <= buffDMAwrite_req;
         sdram_wr_burst <= SDRAM_BURST_W'(BURST_LEN);
         sdram_mask     <= 2'b00;
         case (state)
            IDLE: begin
               idx <= '0;
               if (req_buff && !buffDMAwrite_ack) begin
                  sel_a         <= buffDMAwrite_A_B;
                  sdram_rw_addr <= page_to_word_addr(SDRAM_ADDR_W'(buffDMAwrite_addr), LOG2_BL);
                  state         <= PREFETCH;
               end
            end
            PREFETCH: begin
               // Word 0 read was issued in IDLE/PREFETCH; q is valid from BURST onward
               sdram_wr_req <= 1'b1;
               state        <= BURST;
            end
            BURST: begin
               if (sdram_wr_ack) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(BURST_LEN - 1)) begin
                     sdram_wr_req     <= 1'b0;
                     buffDMAwrite_ack <= 1'b1;
                     state            <= DONE;
                  end
               end
            end
            DONE: begin
               if (!req_buff) begin
                  buffDMAwrite_ack <= 1'b0;
                  idx              <= '0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
   // Running sum of accepted words; cleared at start, frozen from ack until the next start
   always_ff @(posedge clk) begin
      if (reset) begin
         buffDMAwrite_sum <= '0;
      end else if (state == IDLE && req_buff && !buffDMAwrite_ack) begin
         buffDMAwrite_sum <= '0;
      end else if (state == BURST && sdram_wr_ack) begin
         buffDMAwrite_sum <= buffDMAwrite_sum + sdram_din;
      end
   end
`endif

endmodule : sdram_dma_writer

// File: tb/tb_sdram_dma_writer.sv
// Self-checking bench for sdram_dma_writer: vector table for reset/start/gap
// behaviour, then hand-written full-page sequences with a buffer model and a
// reference word/sum model.
module tb_sdram_dma_writer;
   import sdram_dma_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        ack;
   logic [15:0] page_in;
   logic        a_b_in;
   logic [7:0]  rdaddress;
   logic [15:0] a_q, b_q;
   logic        wr_req;
   logic        wr_ack;
   logic [23:0] rw_addr;
   logic [9:0]  wr_burst;
   logic [15:0] din;
   logic [1:0]  mask;
`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
   logic [15:0] sum;
`endif

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sdram_dma_writer #(.BURST_LEN(256), .PAGE_W(16)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .buffDMAwrite_req       (req),
      .buffDMAwrite_ack       (ack),
      .buffDMAwrite_addr      (page_in),
      .buffDMAwrite_A_B       (a_b_in),
      .buffDMAwrite_rdaddress (rdaddress),
      .buffDMAwriteA_q        (a_q),
      .buffDMAwriteB_q        (b_q),
      .sdram_wr_req           (wr_req),
      .sdram_wr_ack           (wr_ack),
      .sdram_rw_addr          (rw_addr),
      .sdram_wr_burst         (wr_burst),
      .sdram_din              (din),
      .sdram_mask             (mask)
`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
      ,
      .buffDMAwrite_sum       (sum)
`endif
   );

   // Dual-port buffers with registered read address (1-cycle latency)
   always_ff @(posedge clk) begin
      a_q <= mem_a[rdaddress];
      b_q <= mem_b[rdaddress];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic        rst;
      logic        rq;
      logic        sel;
      logic [15:0] pg;
      logic        wack;
      logic        e_wr_req;
      logic        e_ack;
      logic [7:0]  e_rd;
      logic [15:0] e_din;
      logic [23:0] e_addr;
   } vec_t;

   vec_t vecs [12];

   // Drive one whole page; stop_at > 0 aborts after that many accepted words
   task automatic do_transfer(input logic [15:0] page, input logic sel, input int mode,
                              input int drop_at, input int stop_at);
      int          n;
      int          k;
      int          c;
      int          din_bad;
      int          rd_bad;
      int          ctrl_bad;
      logic [15:0] exp_w;
      logic [15:0] esum;
      wr_ack  = 1'b0;
      page_in = page;
      a_b_in  = sel;
      req     = 1'b1;
      n = 0;
      do begin
         @(posedge clk); @(negedge clk); n++;
      end while (!wr_req && n < 10);
      chk("start_latency", 32'(n), 32'd3);
      chk("rw_addr", 32'(rw_addr), 32'({page, 8'h00}));
      chk("wr_burst", 32'(wr_burst), 32'd256);
      chk("mask", 32'(mask), 32'd0);
      k = 0; c = 0; din_bad = 0; rd_bad = 0; ctrl_bad = 0; esum = '0;
      while (k < 256 && c < 2000) begin
         if (stop_at > 0 && k == stop_at) break;
         wr_ack = (mode == 0) ? 1'b1 : ((c % 2) == 0);
         if (drop_at >= 0 && c == drop_at) req = 1'b0;
         #1;
         if (ack !== 1'b0 || wr_req !== 1'b1) ctrl_bad++;
         if (rdaddress !== (wr_ack ? 8'(k + 1) : 8'(k))) begin
            if (rd_bad == 0) $display("FAIL rdaddress word %0d: got 0x%0h", k, rdaddress);
            rd_bad++;
         end
         if (wr_ack) begin
            exp_w = sel ? 16'(k) : 16'(32'hFFFF - 32'(k));
            if (din !== exp_w) begin
               if (din_bad == 0) $display("FAIL din word %0d: got 0x%0h expected 0x%0h", k, din, exp_w);
               din_bad++;
            end
            esum = esum + exp_w;
            k++;
         end
         @(posedge clk); @(negedge clk); c++;
      end
      wr_ack = 1'b0;
      chk("din_seq_errors", 32'(din_bad), 32'd0);
      chk("rdaddr_errors", 32'(rd_bad), 32'd0);
      chk("burst_ctrl_errors", 32'(ctrl_bad), 32'd0);
      if (stop_at == 0) begin
         chk("words_accepted", 32'(k), 32'd256);
         chk("ack_on_last_word", 32'(ack), 32'd1);
         chk("wr_req_low_on_last", 32'(wr_req), 32'd0);
`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
         chk("checksum", 32'(sum), 32'(esum));
`endif
      end
   endtask

   task automatic finish_req();
      req = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ack_hold_one_edge", 32'(ack), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("ack_fall_two_edges", 32'(ack), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'(i);
         mem_b[i] = 16'(32'hFFFF - 32'(i));
      end

      //           rst  rq   sel  pg      wack  wr_req ack  rd     din       addr
      vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0, 1'b0,8'd0, 16'hFFFF, 24'h000000};
      vecs[1]  = '{1'b0,1'b1,1'b1,16'h0012,1'b0, 1'b0, 1'b0,8'd0, 16'hFFFF, 24'h000000};
      vecs[2]  = '{1'b0,1'b1,1'b1,16'h0012,1'b0, 1'b0, 1'b0,8'd0, 16'hFFFF, 24'h000000};
      vecs[3]  = '{1'b0,1'b1,1'b1,16'h0012,1'b0, 1'b0, 1'b0,8'd0, 16'h0000, 24'h001200};
      vecs[4]  = '{1'b0,1'b1,1'b1,16'h0012,1'b1, 1'b1, 1'b0,8'd1, 16'h0000, 24'h001200};
      vecs[5]  = '{1'b0,1'b1,1'b1,16'h0012,1'b0, 1'b1, 1'b0,8'd1, 16'h0001, 24'h001200};
      vecs[6]  = '{1'b0,1'b1,1'b1,16'h0012,1'b1, 1'b1, 1'b0,8'd2, 16'h0001, 24'h001200};
      vecs[7]  = '{1'b0,1'b1,1'b1,16'h0012,1'b1, 1'b1, 1'b0,8'd3, 16'h0002, 24'h001200};
      vecs[8]  = '{1'b1,1'b1,1'b1,16'h0012,1'b0, 1'b1, 1'b0,8'd3, 16'h0003, 24'h001200};
      vecs[9]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0, 1'b0,8'd0, 16'hFFFC, 24'h000000};
      vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0, 1'b0,8'd1, 16'hFFFF, 24'h000000};
      vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0, 1'b0,8'd0, 16'hFFFE, 24'h000000};

      reset = 1'b1; req = 1'b0; page_in = '0; a_b_in = 1'b0; wr_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_wr_burst", 32'(wr_burst), 32'd256);
      chk("reset_mask", 32'(mask), 32'd0);

      // Vector table: start latency, gaps, reset mid-burst, spurious ack in IDLE
      for (int i = 0; i < 12; i++) begin
         reset   = vecs[i].rst;
         req     = vecs[i].rq;
         a_b_in  = vecs[i].sel;
         page_in = vecs[i].pg;
         wr_ack  = vecs[i].wack;
         #1;
         chk($sformatf("vec%0d_wr_req", i), 32'(wr_req), 32'(vecs[i].e_wr_req));
         chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
         chk($sformatf("vec%0d_rdaddr", i), 32'(rdaddress), 32'(vecs[i].e_rd));
         chk($sformatf("vec%0d_din", i), 32'(din), 32'(vecs[i].e_din));
         chk($sformatf("vec%0d_rw_addr", i), 32'(rw_addr), 32'(vecs[i].e_addr));
         @(posedge clk); @(negedge clk);
      end
      wr_ack = 1'b0;

      // Reset at idx=100, then a clean full page from buffer A
      do_transfer(16'h0ABC, 1'b1, 0, -1, 100);
      reset = 1'b1; req = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midburst_reset_wr_req", 32'(wr_req), 32'd0);
      chk("midburst_reset_ack", 32'(ack), 32'd0);
      chk("midburst_reset_rdaddr", 32'(rdaddress), 32'd0);
      chk("midburst_reset_addr", 32'(rw_addr), 32'd0);
      @(posedge clk); @(negedge clk);
      do_transfer(16'h0012, 1'b1, 0, -1, 0);
`ifdef SDRAM_DMA_WRITE_CHECKSUM_EN
      chk("checksum_a_ramp", 32'(sum), 32'h7F80);
`endif
      finish_req();

      // Buffer B with wr_ack toggling every cycle
      do_transfer(16'h0345, 1'b0, 1, -1, 0);
      finish_req();

      // req dropped two cycles into BURST: full page, one ack pulse
      do_transfer(16'h0777, 1'b1, 0, 2, 0);
      @(posedge clk); @(negedge clk);
      chk("drop_ack_single_pulse", 32'(ack), 32'd0);
      bad = 0;
      wr_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (wr_req !== 1'b0 || ack !== 1'b0 || rdaddress !== 8'd1) bad++;
         @(posedge clk); @(negedge clk);
      end
      wr_ack = 1'b0;
      #1;
      chk("idle_spurious_wr_ack", 32'(bad), 32'd0);
      chk("idle_idx_zero", 32'(rdaddress), 32'd0);

      // req held high after ack: no second transfer until req toggles
      do_transfer(16'h0100, 1'b1, 0, -1, 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (wr_req !== 1'b0 || ack !== 1'b1) bad++;
      end
      chk("held_req_no_restart", 32'(bad), 32'd0);
      finish_req();
      do_transfer(16'hFFFF, 1'b0, 0, -1, 0);
      chk("top_page_addr", 32'(rw_addr), 32'h00FFFF00);
      finish_req();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sdram_dma_writer
